// File: rtl/aes_ctr_engine.sv
// AES-CTR front end: buffers plaintext, drives an external AES-256 core with the
// counter block, and XORs the keystream. Define AES_CTR_WRAP_ERR_EN to halt on counter wrap.
module aes_ctr_engine #(
  parameter int CTR_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         Iv_Load,
  input  logic [127:0] Iv_In,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [127:0] In_Data,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [127:0] Out_Data,
  output logic         Core_Start,
  output logic [127:0] Core_Block,
  input  logic         Core_Fin,
  input  logic [127:0] Core_Result,
  output logic         Busy,
  output logic         Wrap_Err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [127:0] LOW_MASK =
    (CTR_W >= 128) ? {128{1'b1}} : ((128'd1 << CTR_W) - 128'd1);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t         state, state_nxt;
  logic [127:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [127:0]   ctr, ctr_inc, out_data_q;
  logic           alive, halted;
  logic           push, pop, fifo_empty, fifo_full, ctr_load;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign In_Ready   = alive && !fifo_full && !halted;
  assign push       = In_Valid && In_Ready;
  assign pop        = (state == WAIT) && Core_Fin;
  assign ctr_load   = Iv_Load && (state == IDLE) && fifo_empty;
  // Only the low CTR_W bits count; the nonce part above them is preserved.
  assign ctr_inc    = (ctr & ~LOW_MASK) | ((ctr + 128'd1) & LOW_MASK);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= In_Data;
  end

  // alive keeps In_Ready low for the reset period itself.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      ctr        <= '0;
      out_data_q <= '0;
      alive      <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
      if (ctr_load)
        ctr <= Iv_In;
      else if (pop)
        ctr <= ctr_inc;
      if (pop) out_data_q <= Core_Result ^ mem[rd_ptr];
    end
  end

  always_comb begin
    state_nxt  = state;
    Core_Start = 1'b0;
    Out_Valid  = 1'b0;
    Core_Block = ctr;
    Out_Data   = out_data_q;
    Busy       = (state != IDLE) || !fifo_empty;
    unique case (state)
      IDLE:  if (!fifo_empty && !halted) state_nxt = START;
      START: begin
        Core_Start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:  if (Core_Fin) state_nxt = OUT;
      OUT: begin
        Out_Valid = 1'b1;
        if (Out_Ready) state_nxt = (!fifo_empty && !halted) ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AES_CTR_WRAP_ERR_EN
  logic wrap_err;

  // Sticky until a legal IV reload; a wrap means keystream reuse is imminent.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      wrap_err <= 1'b0;
    else if (ctr_load)
      wrap_err <= 1'b0;
    else if (pop && ((ctr & LOW_MASK) == LOW_MASK))
      wrap_err <= 1'b1;
  end

  assign halted   = wrap_err;
  assign Wrap_Err = wrap_err;
`else
  assign halted   = 1'b0;
  assign Wrap_Err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_ctr_engine.sv
// Self-checking bench for aes_ctr_engine: vector table plus scoreboard of counter
// blocks and result blocks, with hand sequences for latency, backpressure, reset and wrap.
module tb_aes_ctr_engine;

  localparam logic [127:0] IV0    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV1    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] IV0_W8 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfe00;
  localparam logic [127:0] PT1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT1    = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] CT2    = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam logic [127:0] KS1    = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] KS2    = 128'h5a6e699d536119065433863c8f657b94;
  localparam logic [127:0] IVX    = 128'h001122334455667788990aab0000ffff;
  localparam logic [127:0] IVX1   = 128'h001122334455667788990aab00010000;
  localparam logic [127:0] IVZ    = 128'hdeadbeefcafef00d012345677ffffffe;
  localparam logic [127:0] IVL    = 128'h00000000000000000000000000000010;
  localparam logic [127:0] IVW    = 128'h11111111222222223333333344444444;

  logic         CLK = 1'b0, RST_N = 1'b0;
  logic         Iv_Load = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b1, Core_Fin = 1'b0;
  logic [127:0] Iv_In = '0, In_Data = '0, Core_Result = '0;
  logic         In_Ready, Out_Valid, Core_Start, Busy, Wrap_Err;
  logic [127:0] Out_Data, Core_Block;

  logic         Iv_Load_8 = 1'b0, In_Valid_8 = 1'b0, Core_Fin_8 = 1'b0;
  logic [127:0] Iv_In_8 = '0, In_Data_8 = '0, Core_Result_8 = '0;
  logic         In_Ready_8, Out_Valid_8, Core_Start_8, Busy_8, Wrap_Err_8;
  logic [127:0] Out_Data_8, Core_Block_8;

  int checks = 0, errors = 0;
  logic [127:0] exp_blk_q[$], exp_out_q[$];
  logic [127:0] model_ctr, wait_blk;
  logic in_wait = 1'b0, stray_fin = 1'b0, core_busy = 1'b0;
  int core_lat = 2, core_cnt = 0;
  logic [127:0] core_blk = '0;

  aes_ctr_engine #(.CTR_W(32), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .Iv_Load(Iv_Load), .Iv_In(Iv_In),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
    .Core_Start(Core_Start), .Core_Block(Core_Block), .Core_Fin(Core_Fin),
    .Core_Result(Core_Result), .Busy(Busy), .Wrap_Err(Wrap_Err)
  );

  aes_ctr_engine #(.CTR_W(8), .FIFO_DEPTH(4)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .Iv_Load(Iv_Load_8), .Iv_In(Iv_In_8),
    .In_Valid(In_Valid_8), .In_Ready(In_Ready_8), .In_Data(In_Data_8),
    .Out_Valid(Out_Valid_8), .Out_Ready(1'b1), .Out_Data(Out_Data_8),
    .Core_Start(Core_Start_8), .Core_Block(Core_Block_8), .Core_Fin(Core_Fin_8),
    .Core_Result(Core_Result_8), .Busy(Busy_8), .Wrap_Err(Wrap_Err_8)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the AES core: known FIPS-197/SP800-38A keystreams, arbitrary otherwise.
  function automatic logic [127:0] ks_of(input logic [127:0] blk);
    if (blk == IV0) return KS1;
    if (blk == IV1) return KS2;
    return {blk[63:0], blk[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  function automatic logic [127:0] next_ctr32(input logic [127:0] c);
    return {c[127:32], c[31:0] + 32'd1};
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual event missing or unexpected, required none/within budget", name);
  endtask

  always @(negedge CLK) begin
    Core_Fin    = 1'b0;
    Core_Result = {$urandom, $urandom, $urandom, $urandom};
    if (stray_fin) Core_Fin = 1'b1;
    if (core_busy) begin
      if (core_cnt == 0) begin
        Core_Fin    = 1'b1;
        Core_Result = ks_of(core_blk);
        core_busy   = 1'b0;
      end else begin
        core_cnt--;
      end
    end
    if (Core_Start && RST_N) begin
      core_blk  = Core_Block;
      core_busy = 1'b1;
      core_cnt  = core_lat;
    end
  end

  always @(negedge CLK) begin
    if (!RST_N) begin
      in_wait = 1'b0;
    end else begin
      if (Core_Start) begin
        if (exp_blk_q.size() == 0) fail_event("unexpected_core_start");
        else begin
          wait_blk = exp_blk_q.pop_front();
          check_output("core_block", Core_Block, wait_blk);
          in_wait = 1'b1;
        end
      end else if (in_wait && !Out_Valid) begin
        check_output("wait_block_stable", Core_Block, wait_blk);
      end else if (Out_Valid) begin
        in_wait = 1'b0;
      end
      if (Out_Valid) begin
        if (exp_out_q.size() == 0) fail_event("unexpected_out_valid");
        else begin
          check_output("out_data", Out_Data, exp_out_q[0]);
          if (Out_Ready) void'(exp_out_q.pop_front());
        end
      end
    end
  end

  task automatic push_block(input logic [127:0] pt);
    int n = 0;
    In_Valid = 1'b1;
    In_Data  = pt;
    while (!In_Ready && n < 100) begin @(posedge CLK); #1; n++; end
    if (!In_Ready) fail_event("push_timeout");
    @(posedge CLK); #1;
    In_Valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [127:0] blk, input logic [127:0] pt);
    exp_blk_q.push_back(blk);
    exp_out_q.push_back(pt ^ ks_of(blk));
    push_block(pt);
  endtask

  task automatic pulse_iv(input logic [127:0] iv);
    Iv_Load = 1'b1;
    Iv_In   = iv;
    @(posedge CLK); #1;
    Iv_Load = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((Busy || exp_out_q.size() != 0) && n < budget) begin @(posedge CLK); #1; n++; end
    if (Busy || exp_out_q.size() != 0) fail_event("idle_timeout");
  endtask

  task automatic push8(input logic [127:0] pt);
    int n = 0;
    In_Valid_8 = 1'b1;
    In_Data_8  = pt;
    while (!In_Ready_8 && n < 50) begin @(posedge CLK); #1; n++; end
    if (!In_Ready_8) fail_event("push8_timeout");
    @(posedge CLK); #1;
    In_Valid_8 = 1'b0;
  endtask

  task automatic serve8(input logic [127:0] exp_blk, input logic [127:0] pt);
    int n = 0;
    logic [127:0] seen;
    while (!Core_Start_8 && n < 50) begin @(posedge CLK); #1; n++; end
    if (!Core_Start_8) begin
      fail_event("core8_start_timeout");
      return;
    end
    seen = Core_Block_8;
    check_output("core8_block", seen, exp_blk);
    @(posedge CLK); #1;
    Core_Fin_8    = 1'b1;
    Core_Result_8 = ks_of(seen);
    @(posedge CLK); #1;
    Core_Fin_8    = 1'b0;
    Core_Result_8 = '0;
    check_output("out8_valid", 128'(Out_Valid_8), 128'd1);
    check_output("out8_data", Out_Data_8, pt ^ ks_of(exp_blk));
    @(posedge CLK); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"},   128'(In_Ready),   128'd0);
    check_output({tag, "_out_valid"},  128'(Out_Valid),  128'd0);
    check_output({tag, "_core_start"}, 128'(Core_Start), 128'd0);
    check_output({tag, "_core_block"}, Core_Block,       128'd0);
    check_output({tag, "_out_data"},   Out_Data,         128'd0);
    check_output({tag, "_busy"},       128'(Busy),       128'd0);
    check_output({tag, "_wrap_err"},   128'(Wrap_Err),   128'd0);
  endtask

  typedef struct {
    logic         load;
    logic [127:0] iv;
    logic [127:0] pt;
    logic [127:0] blk;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, IV0, PT1, IV0,  CT1};
    vecs[1] = '{1'b0, '0,  PT2, IV1,  CT2};
    vecs[2] = '{1'b1, IVX, 128'h0123456789abcdeffedcba9876543210, IVX,
                128'h0123456789abcdeffedcba9876543210 ^ ks_of(IVX)};
    vecs[3] = '{1'b0, '0,  128'h00000000000000000000000000000001, IVX1,
                128'h00000000000000000000000000000001 ^ ks_of(IVX1)};
    vecs[4] = '{1'b1, IVZ, 128'hffffffffffffffffffffffffffffffff, IVZ,
                128'hffffffffffffffffffffffffffffffff ^ ks_of(IVZ)};

    #12;
    check_reset_values("reset");
    check_output("reset8_in_ready", 128'(In_Ready_8), 128'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].load) begin
        wait_idle(200);
        pulse_iv(vecs[i].iv);
      end
      exp_blk_q.push_back(vecs[i].blk);
      exp_out_q.push_back(vecs[i].ct);
      push_block(vecs[i].pt);
    end
    wait_idle(200);
    check_output("ctr_after_table", Core_Block, next_ctr32(IVZ));
    check_output("wrap_err_32", 128'(Wrap_Err), 128'd0);

    // Push into empty FIFO in cycle N: Core_Start in N+2, Out_Valid the cycle after Core_Fin.
    pulse_iv(IVL);
    core_lat = 4;
    exp_blk_q.push_back(IVL);
    exp_out_q.push_back(PT1 ^ ks_of(IVL));
    In_Valid = 1'b1;
    In_Data  = PT1;
    @(posedge CLK); #1;
    In_Valid = 1'b0;
    check_output("latency_n1_start", 128'(Core_Start), 128'd0);
    @(posedge CLK); #1;
    check_output("latency_n2_start", 128'(Core_Start), 128'd1);
    begin
      int n = 0;
      @(negedge CLK); #1;
      while (!Core_Fin && n < 20) begin @(negedge CLK); #1; n++; end
      if (!Core_Fin) fail_event("fin_timeout");
      check_output("fin_cycle_out_valid", 128'(Out_Valid), 128'd0);
      @(negedge CLK); #1;
      check_output("after_fin_out_valid", 128'(Out_Valid), 128'd1);
    end
    @(posedge CLK); #1;
    wait_idle(100);

    // Backpressure: FIFO fills, results held, stray Core_Fin in OUT ignored.
    model_ctr = next_ctr32(IVL);
    core_lat  = 10;
    Out_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(model_ctr, {$urandom, $urandom, $urandom, $urandom});
      model_ctr = next_ctr32(model_ctr);
    end
    check_output("in_ready_full", 128'(In_Ready), 128'd0);
    apply_stimulus(model_ctr, {$urandom, $urandom, $urandom, $urandom});
    model_ctr = next_ctr32(model_ctr);
    repeat (12) begin @(posedge CLK); #1; end
    stray_fin = 1'b1;
    @(posedge CLK); #1;
    stray_fin = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    check_output("in_ready_full_held", 128'(In_Ready), 128'd0);
    check_output("out_valid_held", 128'(Out_Valid), 128'd1);
    Out_Ready = 1'b1;
    core_lat  = 1;
    wait_idle(300);
    check_output("ctr_after_full", Core_Block, model_ctr);

    // Reset while the core is working; its late Core_Fin must be ignored.
    core_lat = 5;
    apply_stimulus(model_ctr, PT2);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    exp_blk_q.delete();
    exp_out_q.delete();
    #2;
    check_reset_values("midreset");
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (12) begin @(posedge CLK); #1; end
    check_output("post_reset_out_valid", 128'(Out_Valid), 128'd0);
    check_output("post_reset_busy", 128'(Busy), 128'd0);
    check_output("post_reset_ctr", Core_Block, 128'd0);

    // Iv_Load while waiting on the core is ignored.
    core_lat = 6;
    pulse_iv(IVW);
    apply_stimulus(IVW, PT1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    pulse_iv(128'hcccccccccccccccccccccccccccccccc);
    apply_stimulus(next_ctr32(IVW), PT2);
    wait_idle(200);
    check_output("ctr_after_ignored_load", Core_Block, next_ctr32(next_ctr32(IVW)));

    // 8-bit counter field wrapping from ff to 00.
    Iv_Load_8 = 1'b1;
    Iv_In_8   = IV0;
    @(posedge CLK); #1;
    Iv_Load_8 = 1'b0;
`ifdef AES_CTR_WRAP_ERR_EN
    push8(PT1);
    serve8(IV0, PT1);
    check_output("wrap8_err_set", 128'(Wrap_Err_8), 128'd1);
    check_output("wrap8_in_ready", 128'(In_Ready_8), 128'd0);
    check_output("wrap8_ctr", Core_Block_8, IV0_W8);
    repeat (5) begin
      @(posedge CLK); #1;
      check_output("wrap8_no_start", 128'(Core_Start_8), 128'd0);
    end
    Iv_Load_8 = 1'b1;
    Iv_In_8   = IV0;
    @(posedge CLK); #1;
    Iv_Load_8 = 1'b0;
    check_output("wrap8_err_cleared", 128'(Wrap_Err_8), 128'd0);
    check_output("wrap8_resumed", 128'(In_Ready_8), 128'd1);
`else
    push8(PT1);
    push8(PT2);
    serve8(IV0, PT1);
    serve8(IV0_W8, PT2);
    check_output("wrap8_err_zero", 128'(Wrap_Err_8), 128'd0);
    check_output("wrap8_in_ready", 128'(In_Ready_8), 128'd1);
    check_output("wrap8_ctr", Core_Block_8, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfe01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
